// File: rtl/microroc_sc_pkg.sv
// Shared constants and state encoding for the MICROROC slow-control loader.
package microroc_sc_pkg;

    localparam int unsigned SC_WORD_W       = 16;
    localparam int unsigned SC_RSTB_CYC     = 8;
    localparam int unsigned SC_BITS_DEFAULT = 592;
    localparam int unsigned DAC0_W          = 10;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StFetch,
        StShift,
        StDone
    } sc_state_e;

endpackage

// File: rtl/microroc_sc_bit_timer.sv
// Serial bit timing: SR_CK phase counter, per-bit strobes and remaining-bit counter.
module microroc_sc_bit_timer #(
    parameter int unsigned  SC_BITS = 592,
    parameter int unsigned  CK_HALF = 4,
    localparam int unsigned BitW    = $clog2(SC_BITS),
    localparam int unsigned PhW     = $clog2(2 * CK_HALF)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            sr_ck_o,
    output logic            bit_start_o,
    output logic            high_start_o,
    output logic            bit_end_o,
    output logic            frame_end_o,
    output logic [BitW-1:0] bit_idx_o
);

    localparam logic [PhW-1:0] PhaseMax  = PhW'(2 * CK_HALF - 1);
    localparam logic [PhW-1:0] PhaseHigh = PhW'(CK_HALF);

    logic [PhW-1:0]  phase_q, phase_d;
    logic [BitW-1:0] bits_q, bits_d;
    logic            active_q, active_d;
    logic            ck_q, ck_d;

    always_comb begin
        phase_d  = phase_q;
        bits_d   = bits_q;
        active_d = active_q;
        if (start_i) begin
            active_d = 1'b1;
            phase_d  = '0;
            bits_d   = BitW'(SC_BITS - 1);
        end else if (active_q) begin
            if (phase_q == PhaseMax) begin
                phase_d = '0;
                if (bits_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    bits_d = bits_q - 1'b1;
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        // Registered so SR_CK is glitch-free toward the ASIC.
        ck_d = active_d && (phase_d >= PhaseHigh);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= '0;
            bits_q   <= '0;
            active_q <= 1'b0;
            ck_q     <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            bits_q   <= bits_d;
            active_q <= active_d;
            ck_q     <= ck_d;
        end
    end

    assign sr_ck_o      = ck_q;
    assign bit_start_o  = active_q && (phase_q == '0);
    assign high_start_o = active_q && (phase_q == PhaseHigh);
    assign bit_end_o    = active_q && (phase_q == PhaseMax);
    assign frame_end_o  = bit_end_o && (bits_q == '0);
    assign bit_idx_o    = bits_q;

endmodule

// File: rtl/microroc_sc_loader.sv
// Loads a MICROROC slow-control frame from config RAM with DAC0 substituted,
// then pulses MicrorocConfigDone.
module microroc_sc_loader
    import microroc_sc_pkg::*;
#(
    parameter int unsigned  SC_BITS  = SC_BITS_DEFAULT,
    parameter int unsigned  WORD_W   = SC_WORD_W,
    parameter int unsigned  DAC0_POS = 0,
    parameter int unsigned  CK_HALF  = 4,
    localparam int unsigned NWords   = SC_BITS / WORD_W,
    localparam int unsigned AddrW    = $clog2(NWords)
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              LoadSCParameter,
    input  logic [DAC0_W-1:0] OutDAC0,
    output logic [AddrW-1:0]  ScCfgAddr,
    output logic              ScCfgRden,
    input  logic [WORD_W-1:0] ScCfgData,
    output logic              SR_CK,
    output logic              SR_IN,
    output logic              SR_RSTB,
    output logic              MicrorocConfigDone,
    output logic              Busy
);

    localparam int unsigned BitW    = $clog2(SC_BITS);
    localparam int unsigned RstCntW = $clog2(SC_RSTB_CYC);

    sc_state_e           state_q, state_d;
    logic [RstCntW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [DAC0_W-1:0]   dac_q, dac_d;
    logic [AddrW-1:0]    addr_q, addr_d;
    logic                rd_vld_q;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;

    logic                bit_start, high_start, bit_end, frame_end;
    logic [BitW-1:0]     bit_idx;
    logic                word_last, more_words, first_cyc, rden;
    logic [WORD_W-1:0]   first_word, next_word;
    int unsigned         next_k;

    // Overlay the latched DAC0 value onto RAM word k at its frame position.
    function automatic logic [WORD_W-1:0] merge_dac(input logic [WORD_W-1:0] w,
                                                    input int unsigned k,
                                                    input logic [DAC0_W-1:0] dac);
        logic [WORD_W-1:0] r;
        logic [DAC0_W-1:0] sh;
        int unsigned       i;
        r = w;
        for (int unsigned j = 0; j < WORD_W; j++) begin
            i = k * WORD_W + j;
            if (i >= DAC0_POS && i < DAC0_POS + DAC0_W) begin
                sh   = dac >> (i - DAC0_POS);
                r[j] = sh[0];
            end
        end
        return r;
    endfunction

    microroc_sc_bit_timer #(
        .SC_BITS(SC_BITS),
        .CK_HALF(CK_HALF)
    ) u_bit_timer (
        .clk_i       (Clk),
        .rst_i       (reset),
        .start_i     (state_q == StFetch),
        .sr_ck_o     (SR_CK),
        .bit_start_o (bit_start),
        .high_start_o(high_start),
        .bit_end_o   (bit_end),
        .frame_end_o (frame_end),
        .bit_idx_o   (bit_idx)
    );

    assign word_last  = (32'(bit_idx) % WORD_W) == 32'd0;
    assign more_words = bit_idx != '0;
    assign next_k     = 32'(bit_idx) / WORD_W - 32'd1;
    // First cycle of the frame: RAM data is only just valid, so drive it straight through.
    assign first_cyc  = (state_q == StShift) && bit_start && (bit_idx == BitW'(SC_BITS - 1));
    assign first_word = merge_dac(ScCfgData, NWords - 1, dac_q);
    assign next_word  = merge_dac(rd_vld_q ? ScCfgData : hold_q, next_k, dac_q);
    assign rden       = (state_q == StFetch) ||
                        ((state_q == StShift) && high_start && word_last && more_words);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        dac_d     = dac_q;
        addr_d    = addr_q;
        unique case (state_q)
            StIdle: begin
                if (LoadSCParameter) begin
                    state_d   = StRst;
                    rst_cnt_d = '0;
                    dac_d     = OutDAC0;
                    addr_d    = AddrW'(NWords - 1);
                end
            end
            StRst: begin
                if (rst_cnt_q == RstCntW'(SC_RSTB_CYC - 1)) begin
                    state_d = StFetch;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StFetch: state_d = StShift;
            StShift: begin
                if (frame_end) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (rden && addr_q != '0) begin
            addr_d = addr_q - 1'b1;
        end
    end

    always_comb begin
        hold_d = rd_vld_q ? ScCfgData : hold_q;
        sreg_d = sreg_q;
        if (first_cyc) begin
            sreg_d = first_word;
        end else if (state_q == StShift && bit_end) begin
            sreg_d = (word_last && more_words) ? next_word : sreg_q << 1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
            dac_q     <= '0;
            addr_q    <= '0;
            rd_vld_q  <= 1'b0;
            hold_q    <= '0;
            sreg_q    <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            dac_q     <= dac_d;
            addr_q    <= addr_d;
            rd_vld_q  <= rden;
            hold_q    <= hold_d;
            sreg_q    <= sreg_d;
        end
    end

    assign ScCfgAddr          = addr_q;
    assign ScCfgRden          = rden;
    assign SR_RSTB            = state_q != StRst;
    assign MicrorocConfigDone = state_q == StDone;
    assign Busy               = (state_q == StRst) || (state_q == StFetch) ||
                                (state_q == StShift);
    assign SR_IN              = (state_q != StShift) ? 1'b0 :
                                first_cyc ? first_word[WORD_W-1] : sreg_q[WORD_W-1];

endmodule

// File: tb/tb_microroc_sc_loader.sv
// Bench for microroc_sc_loader: cycle-timeline model plus literal frame checks.
module tb_microroc_sc_loader;

    localparam int SC_BITS  = 32;
    localparam int WORD_W   = 16;
    localparam int DAC0_POS = 8;
    localparam int CK_HALF  = 2;
    localparam int DONE_REL = 10 + SC_BITS * 2 * CK_HALF;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        LoadSCParameter = 1'b0;
    logic [9:0]  OutDAC0 = '0;
    logic [0:0]  ScCfgAddr;
    logic        ScCfgRden;
    logic [15:0] ScCfgData = 16'hDEAD;
    logic        SR_CK, SR_IN, SR_RSTB, MicrorocConfigDone, Busy;

    logic [15:0] mem [2];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = -1000;
    int cut = 1 << 30;
    logic [9:0] fdac = '0;

    logic [31:0] cap;
    int ncap, nrden, ndone, done_at, done_total;
    int rise [32];
    int rden_at [4];
    logic ck_prev = 1'b0;

    int rel;
    logic live, e_busy, e_rstb, e_rden, e_ck, e_in, e_done;
    logic [31:0] f;

    microroc_sc_loader #(
        .SC_BITS (SC_BITS),
        .WORD_W  (WORD_W),
        .DAC0_POS(DAC0_POS),
        .CK_HALF (CK_HALF)
    ) dut (
        .Clk               (Clk),
        .reset             (reset),
        .LoadSCParameter   (LoadSCParameter),
        .OutDAC0           (OutDAC0),
        .ScCfgAddr         (ScCfgAddr),
        .ScCfgRden         (ScCfgRden),
        .ScCfgData         (ScCfgData),
        .SR_CK             (SR_CK),
        .SR_IN             (SR_IN),
        .SR_RSTB           (SR_RSTB),
        .MicrorocConfigDone(MicrorocConfigDone),
        .Busy              (Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Registered-read RAM; output is garbage on cycles with no read in flight.
    always @(posedge Clk) ScCfgData <= ScCfgRden ? mem[ScCfgAddr] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic [9:0] d);
        logic [31:0] raw;
        raw = {mem[1], mem[0]};
        return (raw & ~(32'h3FF << DAC0_POS)) | ({22'd0, d} << DAC0_POS);
    endfunction

    // Compare process: expected outputs derived from the cycle offset since T0.
    always @(negedge Clk) begin
        rel    = cyc - t0;
        live   = (cyc < cut) && rel >= 1 && rel <= DONE_REL;
        f      = exp_frame(fdac);
        e_busy = live && rel < DONE_REL;
        e_rstb = !(live && rel <= 8);
        e_rden = live && (rel == 9 || rel == 72);
        e_ck   = live && rel >= 10 && rel < DONE_REL && ((rel - 10) % (2 * CK_HALF)) >= CK_HALF;
        e_in   = (live && rel >= 10 && rel < DONE_REL) ? f[31 - (rel - 10) / (2 * CK_HALF)] : 1'b0;
        e_done = live && rel == DONE_REL;
        chk("busy", 32'(Busy), 32'(e_busy));
        chk("sr_rstb", 32'(SR_RSTB), 32'(e_rstb));
        chk("rden", 32'(ScCfgRden), 32'(e_rden));
        chk("sr_ck", 32'(SR_CK), 32'(e_ck));
        chk("sr_in", 32'(SR_IN), 32'(e_in));
        chk("done", 32'(MicrorocConfigDone), 32'(e_done));
        if (e_rden) chk("addr", 32'(ScCfgAddr), (rel == 9) ? 32'd1 : 32'd0);
        if (SR_CK === 1'b1 && ck_prev === 1'b0) begin
            cap = {cap[30:0], SR_IN};
            if (ncap < 32) rise[ncap] = cyc;
            ncap++;
        end
        ck_prev = SR_CK;
        if (ScCfgRden === 1'b1) begin
            if (nrden < 4) rden_at[nrden] = cyc;
            nrden++;
        end
        if (MicrorocConfigDone === 1'b1) begin
            ndone++;
            done_total++;
            done_at = cyc;
        end
    end

    task automatic start_frame(input logic [9:0] d);
        cap = '0;
        ncap = 0;
        nrden = 0;
        ndone = 0;
        done_at = -1;
        fdac = d;
        t0 = cyc;
        cut = 1 << 30;
        LoadSCParameter = 1'b1;
        OutDAC0 = d;
        @(negedge Clk);
        LoadSCParameter = 1'b0;
        OutDAC0 = 10'($urandom);
    endtask

    initial begin
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        done_total = 0;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        repeat (2) @(negedge Clk);

        // 1: basic frame, prefetch timing, no clock gap at the word boundary
        start_frame(10'h155);
        repeat (145) @(negedge Clk);
        chk("t1_frame", cap, 32'hABCD5534);
        chk("t1_nbits", ncap, 32);
        chk("t1_ndone", ndone, 1);
        chk("t1_done_t", done_at - t0, 138);
        chk("t1_nrden", nrden, 2);
        chk("t1_rden0_t", rden_at[0] - t0, 9);
        chk("t1_rden1_t", rden_at[1] - t0, 72);
        chk("t1_rise0_t", rise[0] - t0, 12);
        chk("t1_gap", rise[16] - rise[15], 4);

        // 2: back-to-back loads, second at the earliest accepted cycle
        done_total = 0;
        start_frame(10'h000);
        repeat (138) @(negedge Clk);
        chk("t2a_frame", cap, 32'hABCC0034);
        chk("t2a_ndone", ndone, 1);
        start_frame(10'h3FF);
        repeat (145) @(negedge Clk);
        chk("t2b_frame", cap, 32'hABCFFF34);
        chk("t2b_ndone", ndone, 1);
        chk("t2_total_done", done_total, 2);

        // 3: load request during a frame is ignored
        start_frame(10'h155);
        repeat (49) @(negedge Clk);
        LoadSCParameter = 1'b1;
        OutDAC0 = 10'h0AA;
        @(negedge Clk);
        LoadSCParameter = 1'b0;
        repeat (95) @(negedge Clk);
        chk("t3_frame", cap, 32'hABCD5534);
        chk("t3_ndone", ndone, 1);
        chk("t3_done_t", done_at - t0, 138);

        // 4: reset mid-frame, then a clean reload
        start_frame(10'h0AA);
        repeat (69) @(negedge Clk);
        reset = 1'b1;
        cut = cyc + 1;
        @(negedge Clk);
        reset = 1'b0;
        chk("t4_ck", 32'(SR_CK), 32'd0);
        chk("t4_rstb", 32'(SR_RSTB), 32'd1);
        chk("t4_busy", 32'(Busy), 32'd0);
        repeat (80) @(negedge Clk);
        chk("t4_ndone", ndone, 0);
        start_frame(10'h2C3);
        repeat (145) @(negedge Clk);
        chk("t4_frame", cap, 32'hABCEC334);
        chk("t4_nbits", ncap, 32);
        chk("t4_done_t", done_at - t0, 138);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
